fp_div_seq: RTL and testbench

//  Sequential, parametrised IEEE-754 binary floating-point divider, result = a / b.

---
 rtl/fp_div_pkg.sv | 43 ++++
 rtl/fp_classify.sv | 26 ++
 rtl/fp_div_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the sequential floating-point divider.
//   state_t      : divider FSM states
//   cls_t        : operand classification
//   calc_w       : total word width from exponent/fraction widths
//   calc_bias    : exponent bias 2^(EXP_W-1)-1
//   qnan_word    : canonical quiet NaN {0, all-ones exponent, 1, 0...}
package fp_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        ROUND,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } cls_t;

    // Canonical single-precision quiet NaN.
    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

    function automatic int unsigned calc_w(input int unsigned exp_w, input int unsigned man_w);
        return 32'd1 + exp_w + man_w;
    endfunction

    function automatic int unsigned calc_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Wide enough for any practical format; callers truncate to their word width.
    function automatic logic [127:0] qnan_word(input int unsigned exp_w, input int unsigned man_w);
        logic [127:0] w;
        w = ((128'd1 << exp_w) - 128'd1) << man_w;
        w = w | (128'd1 << (man_w - 32'd1));
        return w;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Classifies one floating-point operand from its exponent and fraction fields.
//   exp_field  : biased exponent
//   frac_field : stored fraction
//   cls_c      : ZERO (including subnormals), NORM, INF or NAN
module fp_classify
    import fp_div_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
)(
    input  logic [EXP_W-1:0] exp_field,
    input  logic [MAN_W-1:0] frac_field,
    output cls_t             cls_c
);

    // Subnormals collapse to zero; the divider never produces them either.
    always_comb begin
        cls_c = NORM;
        if (exp_field == '0) begin
            cls_c = ZERO;
        end else if (&exp_field) begin
            cls_c = (frac_field == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider, result = a / b.
// Radix-2 restoring division of the significands (one quotient bit per cycle),
// round-to-nearest-even, full special-case handling, valid/ready handshakes.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake; a, b captured on acceptance
//   a, b                : dividend, divisor {sign, exp, frac}
//   out_valid, out_ready: result handshake; result and flags held until taken
//   result              : quotient
//   overflow, underflow, div_by_zero, invalid : at most one set per result
module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter  int unsigned EXP_W = 8,
    parameter  int unsigned MAN_W = 23,
    localparam int unsigned W     = calc_w(EXP_W, MAN_W)
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         div_by_zero,
    output logic         invalid
);

    localparam int unsigned BIAS  = calc_bias(EXP_W);
    localparam int unsigned EW2   = EXP_W + 2;
    localparam int unsigned CNT_W = $clog2(MAN_W + 3);
    localparam logic [W-1:0] QNAN = W'(qnan_word(EXP_W, MAN_W));
    localparam logic signed [EW2-1:0] EXP_MAX = EW2'((32'd1 << EXP_W) - 32'd1);

    state_t                  state;
    logic [W-1:0]            a_q;
    logic [W-1:0]            b_q;
    logic signed [EW2-1:0]   exp_q;
    logic [MAN_W+1:0]        rem_q;
    logic [MAN_W:0]          div_q;
    logic [MAN_W+2:0]        quo_q;
    logic [CNT_W-1:0]        cnt_q;

    cls_t                    cls_a_c;
    cls_t                    cls_b_c;
    logic                    sign_c;
    logic [W-1:0]            inf_w_c;
    logic [W-1:0]            zero_w_c;
    logic                    spec_hit_c;
    logic [W-1:0]            spec_res_c;
    logic                    spec_inv_c;
    logic                    spec_dbz_c;

    logic                    rem_ge_c;
    logic [MAN_W+1:0]        rem_sub_c;

    logic [MAN_W-1:0]        frac_pre_c;
    logic                    guard_c;
    logic                    sticky_c;
    logic signed [EW2-1:0]   exp_adj_c;
    logic                    round_up_c;
    logic [MAN_W:0]          frac_sum_c;
    logic signed [EW2-1:0]   exp_rnd_c;
    logic                    ovf_c;
    logic                    unf_c;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .exp_field  (a_q[W-2:MAN_W]),
        .frac_field (a_q[MAN_W-1:0]),
        .cls_c      (cls_a_c)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .exp_field  (b_q[W-2:MAN_W]),
        .frac_field (b_q[MAN_W-1:0]),
        .cls_c      (cls_b_c)
    );

    assign sign_c   = a_q[W-1] ^ b_q[W-1];
    assign inf_w_c  = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign zero_w_c = {sign_c, {(W-1){1'b0}}};

    // Special-case result selection, highest priority first.
    always_comb begin
        spec_hit_c = 1'b1;
        spec_res_c = '0;
        spec_inv_c = 1'b0;
        spec_dbz_c = 1'b0;
        if (cls_a_c == NAN || cls_b_c == NAN) begin
            spec_res_c = QNAN;
        end else if ((cls_a_c == ZERO && cls_b_c == ZERO) ||
                     (cls_a_c == INF  && cls_b_c == INF)) begin
            spec_res_c = QNAN;
            spec_inv_c = 1'b1;
        end else if (cls_a_c == INF) begin
            spec_res_c = inf_w_c;
        end else if (cls_b_c == INF) begin
            spec_res_c = zero_w_c;
        end else if (cls_a_c == ZERO) begin
            spec_res_c = zero_w_c;
        end else if (cls_b_c == ZERO) begin
            spec_res_c = inf_w_c;
            spec_dbz_c = 1'b1;
        end else begin
            spec_hit_c = 1'b0;
        end
    end

    // One restoring step: the compare produces the quotient bit.
    always_comb begin
        rem_ge_c  = (rem_q >= {1'b0, div_q});
        rem_sub_c = rem_ge_c ? (rem_q - {1'b0, div_q}) : rem_q;
    end

    // Normalise the quotient (ratio lies in (0.5, 2)) and round to nearest even.
    always_comb begin
        if (quo_q[MAN_W+2]) begin
            frac_pre_c = quo_q[MAN_W+1:2];
            guard_c    = quo_q[1];
            sticky_c   = quo_q[0] | (|rem_q);
            exp_adj_c  = exp_q;
        end else begin
            frac_pre_c = quo_q[MAN_W:1];
            guard_c    = quo_q[0];
            sticky_c   = |rem_q;
            exp_adj_c  = exp_q - EW2'(1);
        end
        round_up_c = guard_c & (sticky_c | frac_pre_c[0]);
        // A carry out of the fraction means the mantissa became 2.0: fraction
        // wraps to zero and the exponent takes the carry.
        frac_sum_c = {1'b0, frac_pre_c} + (MAN_W+1)'(round_up_c);
        exp_rnd_c  = exp_adj_c + EW2'(frac_sum_c[MAN_W]);
        ovf_c      = !exp_rnd_c[EW2-1] && (exp_rnd_c >= EXP_MAX);
        unf_c      = exp_rnd_c[EW2-1] || (exp_rnd_c == '0);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            exp_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q         <= a;
                        b_q         <= b;
                        in_ready    <= 1'b0;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        div_by_zero <= 1'b0;
                        invalid     <= 1'b0;
                        state       <= UNPACK;
                    end
                end
                UNPACK: begin
                    exp_q <= EW2'(a_q[W-2:MAN_W]) - EW2'(b_q[W-2:MAN_W]) + EW2'(BIAS);
                    rem_q <= {2'b01, a_q[MAN_W-1:0]};
                    div_q <= {1'b1, b_q[MAN_W-1:0]};
                    quo_q <= '0;
                    cnt_q <= '0;
                    // Special results are committed here and presented from DONE.
                    if (spec_hit_c) begin
                        result      <= spec_res_c;
                        invalid     <= spec_inv_c;
                        div_by_zero <= spec_dbz_c;
                        state       <= DONE;
                    end else begin
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_sub_c << 1;
                    quo_q <= {quo_q[MAN_W+1:0], rem_ge_c};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MAN_W + 2)) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (ovf_c) begin
                        result <= inf_w_c;
                    end else if (unf_c) begin
                        result <= zero_w_c;
                    end else begin
                        result <= {sign_c, exp_rnd_c[EXP_W-1:0], frac_sum_c[MAN_W-1:0]};
                    end
                    overflow  <= ovf_c;
                    underflow <= unf_c;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq (single precision).
module tb_fp_div_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        invalid;

    int n_checks = 0;
    int n_fail   = 0;

    fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({overflow, underflow, div_by_zero, invalid});
    endfunction

    // Issue one operation and check its result, flags and latency.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags,
                          input int exp_lat, input bit do_hs);
        int waited;
        int lat;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({tag, ":ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = op_a;
        b        = op_b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":lat"},    32'(lat),      32'(exp_lat));
        check({tag, ":result"}, result,        exp_res);
        check({tag, ":flags"},  flags(),       32'(exp_flags));
        check({tag, ":busy"},   32'(in_ready), 32'd0);
        if (do_hs) begin
            @(posedge clk);
            #1;
            check({tag, ":ov_low"},   32'(out_valid), 32'd0);
            check({tag, ":ready_up"}, 32'(in_ready),  32'd1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst:in_ready",  32'(in_ready),  32'd1);
        check("rst:out_valid", 32'(out_valid), 32'd0);
        check("rst:result",    result,         32'h0000_0000);
        check("rst:flags",     flags(),        32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Normal divisions.
        run_op("6/2",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 28, 1'b1);
        run_op("1/3",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 28, 1'b1);
        run_op("2/3",   32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 4'b0000, 28, 1'b1);
        run_op("10/4",  32'h4120_0000, 32'h4080_0000, 32'h4020_0000, 4'b0000, 28, 1'b1);
        run_op("-1/2",  32'hBF80_0000, 32'h4000_0000, 32'hBF00_0000, 4'b0000, 28, 1'b1);
        run_op("ovf",   32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b1000, 28, 1'b1);
        run_op("unf",   32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0100, 28, 1'b1);

        // Special cases.
        run_op("1/0",     32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0010, 2, 1'b1);
        run_op("0/0",     32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001, 2, 1'b1);
        run_op("-5/0",    32'hC0A0_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0010, 2, 1'b1);
        run_op("nan/1",   32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000, 2, 1'b1);
        run_op("inf/inf", 32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b0001, 2, 1'b1);
        run_op("-inf/2",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 2, 1'b1);
        run_op("3/inf",   32'h4040_0000, 32'h7F80_0000, 32'h0000_0000, 4'b0000, 2, 1'b1);
        run_op("-0/5",    32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 4'b0000, 2, 1'b1);
        run_op("sub/1",   32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 2, 1'b1);

        // Backpressure: result held, new operands ignored while busy.
        out_ready = 1'b0;
        run_op("bp", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 28, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 32'h40C0_0000;
            b        = 32'h4000_0000;
            @(posedge clk);
            #1;
            check("bp:result",    result,         32'h3EAA_AAAB);
            check("bp:flags",     flags(),        32'd0);
            check("bp:in_ready",  32'(in_ready),  32'd0);
            check("bp:out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp:ov_low",   32'(out_valid), 32'd0);
        check("bp:ready_up", 32'(in_ready),  32'd1);
        run_op("after_bp", 32'h4120_0000, 32'h4080_0000, 32'h4020_0000, 4'b0000, 28, 1'b1);

        // Reset during DIVIDE aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h3F80_0000;
        b        = 32'h4040_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst:out_valid", 32'(out_valid), 32'd0);
        check("midrst:in_ready",  32'(in_ready),  32'd1);
        check("midrst:result",    result,         32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 28, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
